// File: rtl/gen_pipe_elastic_pkg.sv
// Shared definitions for the elastic pipeline register and the core stages that use it.
package gen_pipe_elastic_pkg;

    localparam int PIPE_DW_DEFAULT = 32;

    // addi x0, x0, 0: what an empty slot presents to the next core stage
    localparam logic [PIPE_DW_DEFAULT-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic {
        READY_COMB = 1'b0,
        READY_REG  = 1'b1
    } ready_mode_e;

    function automatic ready_mode_e ready_mode(input int reg_ready);
        return (reg_ready != 0) ? READY_REG : READY_COMB;
    endfunction

endpackage

// File: rtl/gen_pipe_elastic_stage.sv
// One elastic stage: a main register plus a one-entry skid. Ready is supplied by the
// parent, so the same stage serves both the combinational and registered-ready chains.
module gen_pipe_elastic_stage
    import gen_pipe_elastic_pkg::*;
#(
    parameter int DW = PIPE_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          stall,
    input  logic [DW-1:0] def_val,
    input  logic          up_valid_i,
    input  logic [DW-1:0] up_data_i,
    input  logic          up_ready_i,
    input  logic          dn_ready_i,
    output logic          dn_valid_o,
    output logic [DW-1:0] dn_data_o,
    output logic          skid_valid_o
);

    logic          main_vld_q, main_vld_d;
    logic [DW-1:0] main_q, main_d;
    logic          skid_vld_q, skid_vld_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          accept, pop;

    // With a combinational ready the skid never fills: up_ready already implies main is free or leaving.
    always_comb begin
        accept     = up_valid_i & up_ready_i;
        pop        = main_vld_q & dn_ready_i;
        main_vld_d = main_vld_q;
        main_d     = main_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (!main_vld_q || pop) begin
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = accept;
                if (accept) begin
                    main_d = up_data_i;
                end
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_d     = up_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= def_val;
            skid_q     <= def_val;
        end else if (!stall) begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign dn_valid_o   = main_vld_q;
    assign dn_data_o    = main_q;
    assign skid_valid_o = skid_vld_q;

endmodule

// File: rtl/gen_pipe_elastic.sv
// Multi-stage valid/ready pipeline register with flush-to-default, global stall,
// bubble collapsing and an optional registered-ready (skid) mode.
module gen_pipe_elastic
    import gen_pipe_elastic_pkg::*;
#(
    parameter int DW        = PIPE_DW_DEFAULT,
    parameter int STAGES    = 2,
    parameter int REG_READY = 0,
    parameter int CW        = $clog2(STAGES * (1 + REG_READY) + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          stall,
    input  logic [DW-1:0] def_val,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] occupancy
);

    localparam ready_mode_e MODE = ready_mode(REG_READY);

    logic [STAGES:0]          vld_c;
    logic [STAGES:0]          rdy_c;
    logic [STAGES:0][DW-1:0]  dat_c;
    logic [STAGES-1:0]        skid_vld;
    logic                     active, in_fire, out_fire;
    logic [CW-1:0]            occ_q, occ_d;

    assign vld_c[0] = in_valid;
    assign dat_c[0] = in_data;

    // Ready walks from the output back to the input; in registered mode each link is a flop.
    always_comb begin
        rdy_c         = '0;
        rdy_c[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy_c[i] = (MODE == READY_REG) ? !skid_vld[i] : (!vld_c[i+1] || rdy_c[i+1]);
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        gen_pipe_elastic_stage #(
            .DW (DW)
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .flush        (flush),
            .stall        (stall),
            .def_val      (def_val),
            .up_valid_i   (vld_c[g]),
            .up_data_i    (dat_c[g]),
            .up_ready_i   (rdy_c[g]),
            .dn_ready_i   (rdy_c[g+1]),
            .dn_valid_o   (vld_c[g+1]),
            .dn_data_o    (dat_c[g+1]),
            .skid_valid_o (skid_vld[g])
        );
    end

    // Reset, flush and stall all block both ends, so nothing is handed over in those cycles.
    assign active    = rst & !flush & !stall;
    assign in_ready  = rdy_c[0] & active;
    assign out_valid = vld_c[STAGES] & active;
    assign out_data  = dat_c[STAGES];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign occ_d = occ_q + CW'(in_fire) - CW'(out_fire);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_gen_pipe_elastic.sv
// Bench for gen_pipe_elastic: two instances (combinational and registered ready, 3 stages)
// share stimulus; a negedge monitor scoreboards each against its own queue and occupancy model.
module tb_gen_pipe_elastic;

    localparam int STAGES = 3;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] c;
    } ent_t;

    logic        clk;
    logic        rst, flush, stall;
    logic [31:0] def_val;
    logic        in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready_w  [2];
    logic        out_valid_w [2];
    logic [31:0] out_data_w  [2];
    logic [1:0]  occ0;
    logic [2:0]  occ1;
    logic [3:0]  occ_w       [2];

    int          n_chk, n_fail, cyc;
    int          mocc [2];
    ent_t        sb_q [2][$];
    ent_t        e;
    logic        lat_chk;

    gen_pipe_elastic #(.DW(32), .STAGES(STAGES), .REG_READY(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall), .def_val(def_val),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
        .occupancy(occ0)
    );

    gen_pipe_elastic #(.DW(32), .STAGES(STAGES), .REG_READY(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall), .def_val(def_val),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
        .occupancy(occ1)
    );

    assign occ_w[0] = {2'b00, occ0};
    assign occ_w[1] = {1'b0, occ1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: checks occupancy, then records transfers that the next edge will perform.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst || flush) begin
                sb_q[k].delete();
                mocc[k] = 0;
            end else begin
                check($sformatf("dut%0d occupancy", k), occ_w[k], mocc[k]);
                if (out_valid_w[k] && out_ready) begin
                    check($sformatf("dut%0d out_has_expected", k), sb_q[k].size() != 0, 1'b1);
                    if (sb_q[k].size() != 0) begin
                        e = sb_q[k].pop_front();
                        check($sformatf("dut%0d out_data", k), out_data_w[k], e.d);
                        if (lat_chk) check($sformatf("dut%0d latency", k), cyc - int'(e.c), STAGES);
                        mocc[k]--;
                    end
                end
                if (in_valid && in_ready_w[k]) begin
                    sb_q[k].push_back('{d: in_data, c: cyc});
                    mocc[k]++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        n_chk = 0; n_fail = 0; cyc = 0; lat_chk = 1'b0;
        rst = 1'b0; flush = 1'b0; stall = 1'b0; def_val = 32'h0000_0013;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d rst out_data", k), out_data_w[k], 32'h13);
            check($sformatf("dut%0d rst out_valid", k), out_valid_w[k], 1'b0);
            check($sformatf("dut%0d rst occ", k), occ_w[k], 0);
            check($sformatf("dut%0d rst in_ready", k), in_ready_w[k], 1'b0);
        end
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("dut%0d in_ready after rst", k), in_ready_w[k], 1'b1);
        go();

        // Streaming 1..8 back-to-back
        out_ready = 1'b1;
        lat_chk = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            go();
        end
        in_valid = 1'b0;
        repeat (2) go();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d stream last valid", k), out_valid_w[k], 1'b1);
            check($sformatf("dut%0d stream last data", k), out_data_w[k], 32'd8);
        end
        go();
        for (int k = 0; k < 2; k++) check($sformatf("dut%0d stream drained", k), out_valid_w[k], 1'b0);
        repeat (2) go();
        lat_chk = 1'b0;

        // Back-pressure fill then drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        done      = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            in_data = 100 + i;
            go();
            if (!in_ready_w[0] && !in_ready_w[1]) done = 1'b1;
        end
        check("bp fill reached full", done, 1'b1);
        check("dut0 bp occ", occ_w[0], 3);
        check("dut1 bp occ", occ_w[1], 6);
        for (int k = 0; k < 2; k++) check($sformatf("dut%0d bp head", k), out_data_w[k], 32'd100);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("dut1 bp drain no gap", out_valid_w[1], 1'b1);
            if (i < 3) check("dut0 bp drain no gap", out_valid_w[0], 1'b1);
            go();
        end
        for (int k = 0; k < 2; k++) check($sformatf("dut%0d bp empty", k), out_valid_w[k], 1'b0);

        // Stall mid-stream
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 200 + i;
            go();
        end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 210 + i;
            #1;
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d stall in_ready", k), in_ready_w[k], 1'b0);
                check($sformatf("dut%0d stall out_valid", k), out_valid_w[k], 1'b0);
                check($sformatf("dut%0d stall occ", k), occ_w[k], 3);
            end
            go();
        end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 220 + i;
            go();
        end
        in_valid = 1'b0;
        repeat (6) go();

        // Flush together with stall and a valid input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 300;
        go();
        in_data   = 301;
        go();
        stall   = 1'b1;
        flush   = 1'b1;
        in_data = 32'h0000_00AA;
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("dut%0d flush in_ready", k), in_ready_w[k], 1'b0);
        go();
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d flush occ", k), occ_w[k], 0);
            check($sformatf("dut%0d flush out_valid", k), out_valid_w[k], 1'b0);
            check($sformatf("dut%0d flush out_data", k), out_data_w[k], 32'h13);
            check($sformatf("dut%0d flush in_ready", k), in_ready_w[k], 1'b1);
        end
        out_ready = 1'b1;
        repeat (5) go();
        for (int k = 0; k < 2; k++) check($sformatf("dut%0d flush no capture", k), out_valid_w[k], 1'b0);

        // Random valid/ready/stall with rare flushes
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = (c < 5000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 15) == 0);
            flush     = ($urandom_range(0, 499) == 0);
            go();
        end
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) go();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d final queue empty", k), sb_q[k].size(), 0);
            check($sformatf("dut%0d final out_valid", k), out_valid_w[k], 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
